// File: rtl/mem_lsu.sv
// Load/store unit for the MEM stage: turns an EX/MEM memory op into one bus
// transaction and formats the load result for write-back.
module mem_lsu #(
  parameter int ADDR_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [31:0]           wdata_i,
  input  logic [3:0]            mem_op_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [31:0]           reg2_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [31:0]           wdata_o,
  output logic                  stall_req_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [31:0]           mem_data_o,
  input  logic                  mem_ack_i,
  input  logic [31:0]           mem_rdata_i,
  output logic                  exc_misalign_o,
  output logic                  exc_buserr_o
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  state_t              state_r, state_s;
  logic [7:0]          cnt_r;
  logic [REG_ADDR_W-1:0] wd_r;
  logic [3:0]          op_r;
  logic [1:0]          off_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [3:0]          be_r;
  logic                we_r;
  logic                ld_r;
  logic [31:0]         sdata_r;
  logic [31:0]         result_r;
  logic                abort_r;

  logic                is_load_s, is_store_s, aligned_s, start_s, timeout_s;
  logic [3:0]          be_s;
  logic [31:0]         sdata_s;

  function automatic logic [31:0] fmt_load(input logic [3:0] op, input logic [1:0] off,
                                           input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{off, 3'b000} +: 8];
    h = off[1] ? rd[31:16] : rd[15:0];
    case (op)
      OP_LB:   fmt_load = {{24{b[7]}}, b};
      OP_LBU:  fmt_load = {24'd0, b};
      OP_LH:   fmt_load = {{16{h[15]}}, h};
      OP_LHU:  fmt_load = {16'd0, h};
      OP_LW:   fmt_load = rd;
      default: fmt_load = 32'd0;
    endcase
  endfunction

  // Decode the incoming op into size class, alignment, lanes and store data
  always_comb begin
    is_load_s  = 1'b0;
    is_store_s = 1'b0;
    aligned_s  = 1'b1;
    be_s       = 4'b0000;
    sdata_s    = 32'd0;
    case (mem_op_i)
      OP_LB, OP_LBU, OP_SB: begin
        is_load_s  = (mem_op_i != OP_SB);
        is_store_s = (mem_op_i == OP_SB);
        be_s       = 4'b0001 << mem_addr_i[1:0];
        sdata_s    = {4{reg2_i[7:0]}};
      end
      OP_LH, OP_LHU, OP_SH: begin
        is_load_s  = (mem_op_i != OP_SH);
        is_store_s = (mem_op_i == OP_SH);
        aligned_s  = ~mem_addr_i[0];
        be_s       = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        sdata_s    = {2{reg2_i[15:0]}};
      end
      OP_LW, OP_SW: begin
        is_load_s  = (mem_op_i == OP_LW);
        is_store_s = (mem_op_i == OP_SW);
        aligned_s  = (mem_addr_i[1:0] == 2'b00);
        be_s       = 4'b1111;
        sdata_s    = reg2_i;
      end
      default: begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
      end
    endcase
    if (!is_store_s) begin
      sdata_s = 32'd0;
    end else begin
      sdata_s = sdata_s;
    end
  end

  assign start_s   = (is_load_s | is_store_s) & aligned_s;
  assign timeout_s = (cnt_r == CNT_LAST);

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = start_s ? REQ : IDLE;
      REQ:     state_s = (mem_ack_i || timeout_s) ? DONE : REQ;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, wait counter and transaction capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= 8'd0;
      wd_r     <= '0;
      op_r     <= 4'd0;
      off_r    <= 2'd0;
      addr_r   <= '0;
      be_r     <= 4'd0;
      we_r     <= 1'b0;
      ld_r     <= 1'b0;
      sdata_r  <= 32'd0;
      result_r <= 32'd0;
      abort_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: if (start_s) begin
          cnt_r    <= 8'd0;
          wd_r     <= wd_i;
          op_r     <= mem_op_i;
          off_r    <= mem_addr_i[1:0];
          addr_r   <= {mem_addr_i[ADDR_W-1:2], 2'b00};
          be_r     <= be_s;
          we_r     <= is_store_s;
          ld_r     <= is_load_s;
          sdata_r  <= sdata_s;
          result_r <= 32'd0;
          abort_r  <= 1'b0;
        end
        REQ: begin
          if (mem_ack_i) begin
            result_r <= fmt_load(op_r, off_r, mem_rdata_i);
          end else begin
            cnt_r   <= cnt_r + 8'd1;
            abort_r <= timeout_s;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode; pass-through in IDLE keeps non-memory instructions stall-free
  always_comb begin
    wd_o           = '0;
    wreg_o         = 1'b0;
    wdata_o        = 32'd0;
    stall_req_o    = 1'b0;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_o     = '0;
    mem_be_o       = 4'd0;
    mem_data_o     = 32'd0;
    exc_misalign_o = 1'b0;
    exc_buserr_o   = 1'b0;
    if (rst) begin
      wd_o = '0;
    end else begin
      case (state_r)
        IDLE: begin
          wd_o    = wd_i;
          wdata_o = wdata_i;
          if (!(is_load_s || is_store_s)) begin
            wreg_o = wreg_i;
          end else if (!aligned_s) begin
            exc_misalign_o = 1'b1;
          end else begin
            stall_req_o = 1'b1;
          end
        end
        REQ: begin
          wd_o        = wd_r;
          stall_req_o = 1'b1;
          mem_req_o   = 1'b1;
          mem_we_o    = we_r;
          mem_addr_o  = addr_r;
          mem_be_o    = be_r;
          mem_data_o  = sdata_r;
        end
        DONE: begin
          wd_o         = wd_r;
          wreg_o       = ld_r & ~abort_r;
          wdata_o      = (ld_r && !abort_r) ? result_r : 32'd0;
          exc_buserr_o = abort_r;
        end
        default: wd_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized bench for mem_lsu: each transaction is predicted cycle by cycle
// from size/offset arithmetic and compared at the falling edge.
module tb_mem_lsu;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stall_req_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_data_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        exc_misalign_o, exc_buserr_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] done_wdata;

  always #5 clk = ~clk;

  mem_lsu #(.ADDR_W(32), .REG_ADDR_W(5), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stall_req_o(stall_req_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .exc_misalign_o(exc_misalign_o),
    .exc_buserr_o(exc_buserr_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int op_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd6: return 1;
      4'd3, 4'd4, 4'd7: return 2;
      4'd5, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd);
    int sz = op_size(op);
    logic [31:0] mask, v;
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v = (rd >> (8 * (addr % 4))) & mask;
    if ((op == 4'd1 || op == 4'd3) && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input int sz, input logic [31:0] addr);
    int m = (1 << sz) - 1;
    return 4'(m << (addr % 4));
  endfunction

  function automatic logic [31:0] ref_sdata(input int sz, input logic [31:0] r);
    if (sz == 1) return r[7:0] * 32'h0101_0101;
    if (sz == 2) return r[15:0] * 32'h0001_0001;
    return r;
  endfunction

  task automatic rand_inputs();
    wd_i       = 5'($urandom);
    wreg_i     = 1'($urandom);
    wdata_i    = $urandom;
    mem_op_i   = 4'($urandom);
    mem_addr_i = $urandom;
    reg2_i     = $urandom;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {wd_o, wreg_o, stall_req_o, mem_req_o, mem_we_o, mem_be_o,
                exc_misalign_o, exc_buserr_o}, 32'd0);
    check({tag, "_d"}, wdata_o | mem_addr_o | mem_data_o, 32'd0);
  endtask

  task automatic txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] r2,
                     input logic [4:0] wd, input logic wr, input logic [31:0] wdat,
                     input int ack_wait, input logic [31:0] rdat, input int rst_at);
    int sz = op_size(op);
    bit isld = (op >= 4'd1 && op <= 4'd5);
    bit tmo;
    int nreq;
    @(posedge clk); #1;
    rst = 1'b0; mem_op_i = op; mem_addr_i = addr; reg2_i = r2;
    wd_i = wd; wreg_i = wr; wdata_i = wdat;
    mem_ack_i = 1'($urandom); mem_rdata_i = $urandom;
    @(negedge clk);
    if (sz == 0) begin
      check("pass_wd", 32'(wd_o), 32'(wd));
      check("pass_wreg", 32'(wreg_o), 32'(wr));
      check("pass_wdata", wdata_o, wdat);
      check("pass_stall", {stall_req_o, mem_req_o, exc_misalign_o, exc_buserr_o}, 32'd0);
      return;
    end
    if ((addr % sz) != 0) begin
      check("mis_exc", 32'(exc_misalign_o), 32'd1);
      check("mis_quiet", {wreg_o, stall_req_o, mem_req_o}, 32'd0);
      @(posedge clk); #1;
      mem_op_i = 4'd0;
      @(negedge clk);
      check("mis_pulse", {exc_misalign_o, mem_req_o, stall_req_o}, 32'd0);
      return;
    end
    check("idle_stall", {stall_req_o, wreg_o, mem_req_o, exc_misalign_o}, 32'b1000);
    tmo  = (ack_wait >= TMO);
    nreq = tmo ? TMO : ack_wait + 1;
    for (int k = 0; k < nreq; k++) begin
      @(posedge clk); #1;
      rand_inputs();
      mem_ack_i   = (k == ack_wait);
      mem_rdata_i = (k == ack_wait) ? rdat : $urandom;
      rst         = (k == rst_at);
      @(negedge clk);
      if (rst) begin
        check_all_zero("rst_zero");
        @(posedge clk); #1;
        rst = 1'b0; mem_op_i = 4'd0; wreg_i = 1'b0; wd_i = 5'($urandom); mem_ack_i = 1'b0;
        @(negedge clk);
        check("rst_idle_wd", 32'(wd_o), 32'(wd_i));
        check("rst_quiet", {wreg_o, stall_req_o, mem_req_o, exc_misalign_o, exc_buserr_o}, 32'd0);
        return;
      end
      check("req_ctl", {mem_req_o, stall_req_o, mem_we_o, wreg_o, exc_misalign_o},
            {27'd0, 1'b1, 1'b1, 1'(op >= 4'd6), 1'b0, 1'b0});
      check("req_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
      check("req_be", 32'(mem_be_o), 32'(ref_be(sz, addr)));
      if (!isld) check("req_data", mem_data_o, ref_sdata(sz, r2));
    end
    @(posedge clk); #1;
    rand_inputs();
    mem_ack_i = 1'($urandom); mem_rdata_i = $urandom;
    @(negedge clk);
    done_wdata = wdata_o;
    check("done_ctl", {stall_req_o, mem_req_o, exc_misalign_o}, 32'd0);
    check("done_wd", 32'(wd_o), 32'(wd));
    check("done_wreg", 32'(wreg_o), 32'(isld && !tmo));
    check("done_wdata", wdata_o, (isld && !tmo) ? ref_load(op, addr, rdat) : 32'd0);
    check("done_buserr", 32'(exc_buserr_o), 32'(tmo));
  endtask

  initial begin
    rst = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = $urandom;
    rand_inputs();
    mem_op_i = 4'd5; wreg_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("reset2");

    txn(4'd0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h0000_1234, 0, 32'h0, -1);
    txn(4'd1, 32'h0000_1003, 32'h0, 5'd7, 1'b0, 32'h0, 2, 32'h80FF_0000, -1);
    check("lb_const", done_wdata, 32'hFFFF_FF80);
    txn(4'd2, 32'h0000_1003, 32'h0, 5'd8, 1'b0, 32'h0, 2, 32'h80FF_0000, -1);
    check("lbu_const", done_wdata, 32'h0000_0080);
    txn(4'd7, 32'h0000_2002, 32'h0000_ABCD, 5'd9, 1'b1, 32'h0, 0, 32'h0, -1);
    txn(4'd5, 32'h0000_3001, 32'h0, 5'd3, 1'b1, 32'h0, 0, 32'h0, -1);
    txn(4'd5, 32'h0000_4000, 32'h0, 5'd4, 1'b0, 32'h0, 9, 32'h0, -1);
    txn(4'd5, 32'h0000_4000, 32'h0, 5'd4, 1'b0, 32'h0, TMO - 1, 32'hCAFE_F00D, -1);
    txn(4'd5, 32'h0000_5000, 32'h0, 5'd6, 1'b0, 32'h0, 5, 32'h0, 1);

    for (int i = 0; i < 300; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 9) == 9) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      txn(op, $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom,
          $urandom_range(0, 5), $urandom,
          ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, byte-address width; REG_ADDR_W, default 5, register-index width; TIMEOUT_CYC, default 255, maximum cycles in REQ before abort (range 1..255). Data width SHALL be fixed at 32.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high. Ports are listed as name, direction, width, meaning.
REQ-003 clk  in  1  clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 wd_i  in  REG_ADDR_W  destination register index from EX/MEM.
REQ-006 wreg_i  in  1  write-enable from EX/MEM.
REQ-007 wdata_i  in  32  ALU result from EX/MEM.
REQ-008 mem_op_i  in  4  memory operation: 0=none, 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LW, 6=SB, 7=SH, 8=SW; any other value SHALL be treated as none.
REQ-009 mem_addr_i  in  ADDR_W  effective byte address.
REQ-010 reg2_i  in  32  store data.
REQ-011 wd_o / wreg_o / wdata_o  out  REG_ADDR_W / 1 / 32  write-back destination, enable and value.
REQ-012 stall_req_o  out  1  pipeline stall request.
REQ-013 mem_req_o, mem_we_o  out  1 each  bus request and write strobe.
REQ-014 mem_addr_o  out  ADDR_W  word-aligned bus address, with bits [1:0] = 0.
REQ-015 mem_be_o  out  4  byte-lane enables, little-endian, so lane k covers data bits [8k+7:8k].
REQ-016 mem_data_o  out  32  store data, replicated onto the addressed lanes.
REQ-017 mem_ack_i  in  1  bus completion; mem_rdata_i  in  32  read data, valid when mem_ack_i=1.
REQ-018 exc_misalign_o, exc_buserr_o  out  1 each  exception pulses.

Function
REQ-019 The FSM SHALL have the states IDLE, REQ and DONE.
REQ-020 In IDLE, for op=none, outputs SHALL pass through combinationally: wd_o=wd_i, wreg_o=wreg_i, wdata_o=wdata_i, stall_req_o=0.
REQ-021 In IDLE, for an aligned memory op, the block SHALL assert stall_req_o=1 and force wreg_o=0. It SHALL capture wd_i, op, addr[1:0], bus address, mem_be_o and store data at the clock edge and move to REQ.
REQ-022 Alignment SHALL be defined as follows: LH/LHU/SH require addr[0]=0; LW/SW require addr[1:0]=0. Byte ops are always aligned.
REQ-023 A misaligned op in IDLE SHALL produce the following in the same cycle: exc_misalign_o=1, wreg_o=0, stall_req_o=0, mem_req_o=0. The state SHALL remain IDLE.
REQ-024 In REQ, mem_req_o=1 and stall_req_o=1 SHALL be asserted, and address, we, be and data SHALL be held constant until mem_ack_i=1.
REQ-025 On mem_ack_i=1 in REQ, the block SHALL register the formatted load result and move to DONE. The request therefore drops in the cycle after the ack.
REQ-026 Load formatting: LB/LBU SHALL select byte addr[1:0]; LH/LHU SHALL select halfword addr[1]; LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; LW SHALL pass the word.
REQ-027 Store lanes: SB SHALL drive be = 1<<addr[1:0] with data = {4{reg2_i[7:0]}}. SH SHALL drive be = 0011 or 1100 with data = {2{reg2_i[15:0]}}. SW SHALL drive be = 1111. Loads SHALL drive the be of the accessed lanes with mem_we_o=0.
REQ-028 The wait counter SHALL clear on entry to REQ and increment each REQ cycle without ack.
REQ-029 If the counter reaches TIMEOUT_CYC with no ack, the block SHALL go to DONE with the abort flag set.
REQ-030 An ack arriving in the same cycle as the timeout SHALL win, and the access SHALL complete normally.
REQ-031 DONE SHALL last exactly one cycle with stall_req_o=0. Outputs SHALL be wd_o = captured index; wreg_o=1 for a successful load, otherwise 0; wdata_o = load result, otherwise 0. Inputs SHALL be ignored in DONE.
REQ-032 After an aborted access, DONE SHALL drive exc_buserr_o=1 for one cycle with wreg_o=0.
REQ-033 DONE SHALL always transition to IDLE.
REQ-034 Minimum latency: a load with ack in its first REQ cycle SHALL stall for 2 cycles (IDLE and REQ) and write back in the third cycle.
REQ-035 mem_ack_i SHALL be ignored outside REQ.

Reset
REQ-036 While rst=1, all outputs SHALL be forced to 0 combinationally.
REQ-037 At the clock edge with rst=1, the state SHALL become IDLE, and the counter and all capture registers SHALL become 0.
REQ-038 Reset asserted in REQ or DONE SHALL abandon the access with no write-back and no exception.

Verification
REQ-039 op=0, wd_i=5, wreg_i=1, wdata_i=0x00001234 -> same cycle wd_o=5, wreg_o=1, wdata_o=0x00001234, stall_req_o=0.
REQ-040 LB, addr 0x00001003, ack after 2 wait cycles with rdata 0x80FF0000 -> mem_addr_o=0x00001000, be=1000, we=0, stall for 4 cycles, then DONE with wreg_o=1 and wdata_o=0xFFFFFF80 (LBU gives 0x00000080).
REQ-041 SH, addr 0x00002002, reg2_i=0x0000ABCD -> be=1100, mem_data_o=0xABCDABCD, we=1, DONE with wreg_o=0.
REQ-042 LW, addr 0x00003001 -> exc_misalign_o=1 for one cycle, mem_req_o stays 0, stall_req_o=0.
REQ-043 TIMEOUT_CYC=4, no ack -> REQ held for 4 cycles, then DONE with exc_buserr_o=1 and wreg_o=0; a repeat run with ack in the 4th cycle completes normally.
REQ-044 rst=1 during the 2nd REQ cycle -> all outputs 0 immediately, state IDLE next cycle, no write-back.
